// File: rtl/rede_out_collector_if.sv
// Collector bus: processor-side strobe/result inputs and system-side FWFT stream.
// master = collector (drives the stream), slave = processor/consumer side.
interface rede_out_collector_if #(
    parameter int NBITS  = 28,
    parameter int NUIOOU = 4,
    parameter int CHW    = 2
);
    logic signed [NBITS-1:0] io_out;
    logic [NUIOOU-1:0]       out_en;
    logic [NBITS-1:0]        m_data;
    logic [CHW-1:0]          m_chan;
    logic                    m_valid;
    logic                    m_ready;

    modport master (
        input  io_out,
        input  out_en,
        input  m_ready,
        output m_data,
        output m_chan,
        output m_valid
    );

    modport slave (
        output io_out,
        output out_en,
        output m_ready,
        input  m_data,
        input  m_chan,
        input  m_valid
    );
endinterface

// File: rtl/rede_out_collector.sv
// Captures one-hot strobed processor results into a tagged FWFT FIFO drained by valid/ready.
// Latency 1 cycle push-to-visible; never stalls the producer: drops on full, flags bad strobes.
module rede_out_collector #(
    parameter int NBITS  = 28,
    parameter int NUIOOU = 4,
    parameter int CHW    = 2,
    parameter int FDEPTH = 8,
    parameter int CNTW   = 8
) (
    input  logic              clk,
    input  logic              rst,
    rede_out_collector_if.master bus,
    output logic              ovf,
    output logic              err,
    output logic [CNTW-1:0]   drop_cnt,
    input  logic              clr_err
);
    localparam int PW = $clog2(FDEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [CHW-1:0]   chan;
        logic [NBITS-1:0] data;
    } entry_t;

    entry_t        mem [FDEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic           one_hot;
    logic           multi_hot;
    logic [CHW-1:0] tag;
    logic           pop;
    logic           full;
    logic           push;
    logic           drop;
    logic [CW-1:0]  count_next;
    logic [CW-1:0]  count_after_pop;
    logic [PW-1:0]  rd_next;
    logic [PW-1:0]  wr_next;
    entry_t         new_entry;
    entry_t         head_next;

    always_comb begin
        tag       = '0;
        one_hot   = ($countones(bus.out_en) == 1);
        multi_hot = ($countones(bus.out_en) > 1);
        for (int i = 0; i < NUIOOU; i++) begin
            if (bus.out_en[i]) tag = CHW'(i);
        end
    end

    // m_valid mirrors count!=0, so it doubles as the "not empty" qualifier for m_ready.
    assign pop             = bus.m_valid & bus.m_ready;
    assign full            = (count == CW'(FDEPTH));
    assign push            = one_hot & (~full | pop);
    assign drop            = one_hot & full & ~pop;
    assign count_after_pop = count - CW'(pop);
    assign count_next      = count_after_pop + CW'(push);
    assign rd_next         = rd_ptr + PW'(pop);
    assign wr_next         = wr_ptr + PW'(push);
    assign new_entry       = '{chan: tag, data: bus.io_out};

    // When the entry being written becomes the head, bypass the memory read.
    always_comb begin
        head_next = mem[rd_next];
        if (push && (count_after_pop == '0)) head_next = new_entry;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= new_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_chan  <= '0;
        end else begin
            rd_ptr      <= rd_next;
            wr_ptr      <= wr_next;
            count       <= count_next;
            bus.m_valid <= (count_next != '0);
            if (count_next != '0) begin
                bus.m_data <= head_next.data;
                bus.m_chan <= head_next.chan;
            end
        end
    end

    // A fault occurring in the same cycle as clr_err takes precedence over the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf      <= 1'b0;
            err      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (drop)         ovf <= 1'b1;
            else if (clr_err) ovf <= 1'b0;

            if (multi_hot)    err <= 1'b1;
            else if (clr_err) err <= 1'b0;

            if (drop) begin
                if (clr_err)        drop_cnt <= CNTW'(1);
                else if (~&drop_cnt) drop_cnt <= drop_cnt + CNTW'(1);
            end else if (clr_err) begin
                drop_cnt <= '0;
            end
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst) count <= CW'(FDEPTH));
    a_head_stable: assert property (@(posedge clk) disable iff (!rst)
        (bus.m_valid && !bus.m_ready) |=> (bus.m_valid && $stable(bus.m_data) && $stable(bus.m_chan)));
endmodule

// File: tb/tb_rede_out_collector.sv
// Randomized scoreboard bench for rede_out_collector against a queue-based reference model.
module tb_rede_out_collector;
    localparam int NBITS  = 28;
    localparam int NUIOOU = 4;
    localparam int CHW    = 2;
    localparam int FDEPTH = 8;
    localparam int CNTW   = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            clr_err;
    logic            ovf;
    logic            err;
    logic [CNTW-1:0] drop_cnt;

    always #5 clk = ~clk;

    rede_out_collector_if #(.NBITS(NBITS), .NUIOOU(NUIOOU), .CHW(CHW)) bus ();

    rede_out_collector #(
        .NBITS(NBITS), .NUIOOU(NUIOOU), .CHW(CHW), .FDEPTH(FDEPTH), .CNTW(CNTW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.master),
        .ovf      (ovf),
        .err      (err),
        .drop_cnt (drop_cnt),
        .clr_err  (clr_err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: expected entries {chan,data}, occupancy, and flag state.
    logic [CHW+NBITS-1:0] exp_q[$];
    int                   mcount;
    logic                 m_ovf;
    logic                 m_err;
    int                   m_drop;
    logic [CHW+NBITS-1:0] last_ent;

    function automatic void check(string name, logic [63:0] act, logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        mcount   = 0;
        m_ovf    = 1'b0;
        m_err    = 1'b0;
        m_drop   = 0;
        last_ent = '0;
    endfunction

    // Called just after a rising edge; applies inputs for the next edge and checks status after it.
    task automatic step(input logic [NUIOOU-1:0] en, input logic [NBITS-1:0] d,
                        input logic rdy, input logic clr);
        bit     will_pop;
        int     ones;
        int     ch;
        bit     accepted;
        bit     dropped;
        bus.out_en = en;
        bus.io_out = d;
        bus.m_ready = rdy;
        clr_err = clr;

        ones = $countones(en);
        ch = 0;
        for (int i = 0; i < NUIOOU; i++) if (en[i]) ch = i;
        will_pop = (mcount > 0) && rdy;
        accepted = (ones == 1) && ((mcount < FDEPTH) || will_pop);
        dropped  = (ones == 1) && !accepted;
        if (accepted) exp_q.push_back({CHW'(ch), d});
        mcount = mcount + (accepted ? 1 : 0) - (will_pop ? 1 : 0);

        if (clr) begin
            m_ovf = 1'b0;
            m_err = 1'b0;
            m_drop = 0;
        end
        if (dropped) begin
            m_ovf = 1'b1;
            if (m_drop < (1 << CNTW) - 1) m_drop++;
        end
        if (ones > 1) m_err = 1'b1;

        @(posedge clk);
        #1;
        check("m_valid", 64'(bus.m_valid), 64'(mcount != 0));
        check("ovf", 64'(ovf), 64'(m_ovf));
        check("err", 64'(err), 64'(m_err));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * FDEPTH && mcount > 0; i++) step('0, '0, 1'b1, 1'b0);
        check("drain_done", 64'(mcount), 64'd0);
    endtask

    // Monitor: at the falling edge, a presented head either pops now or must match the queue front.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.m_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 64'(bus.m_valid), 64'd0);
                end else begin
                    check("m_chan", 64'(bus.m_chan), 64'(exp_q[0][CHW+NBITS-1:NBITS]));
                    check("m_data", 64'(bus.m_data), 64'(exp_q[0][NBITS-1:0]));
                    if (bus.m_ready) last_ent = exp_q.pop_front();
                end
            end else begin
                check("hold_chan", 64'(bus.m_chan), 64'(last_ent[CHW+NBITS-1:NBITS]));
                check("hold_data", 64'(bus.m_data), 64'(last_ent[NBITS-1:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [NUIOOU-1:0] en;
        int                r;

        model_clear();
        rst = 1'b0;
        clr_err = 1'b0;
        bus.out_en = '0;
        bus.io_out = '0;
        bus.m_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_valid", 64'(bus.m_valid), 64'd0);
            check("rst_data", 64'(bus.m_data), 64'd0);
            check("rst_chan", 64'(bus.m_chan), 64'd0);
            check("rst_flags", 64'({ovf, err, drop_cnt}), 64'd0);
        end
        rst = 1'b1;

        repeat (10) step('0, '0, 1'b0, 1'b0);

        // Single push of -5 on port 2; visible one cycle later, gone the cycle after.
        step(4'b0100, 28'hFFFFFFB, 1'b1, 1'b0);
        check("lat_valid", 64'(bus.m_valid), 64'd1);
        check("lat_data", 64'(bus.m_data), 64'h0FFFFFFB);
        check("lat_chan", 64'(bus.m_chan), 64'd2);
        step('0, '0, 1'b1, 1'b0);
        check("lat_empty", 64'(bus.m_valid), 64'd0);

        // Ordering under backpressure.
        step(4'b0001, 28'd10, 1'b0, 1'b0);
        step(4'b1000, 28'd20, 1'b0, 1'b0);
        step(4'b0010, 28'd30, 1'b0, 1'b0);
        repeat (2) step('0, '0, 1'b0, 1'b0);
        drain();
        step('0, '0, 1'b1, 1'b0);

        // Overflow: ten pushes into an eight-deep FIFO.
        for (int i = 0; i < 10; i++) step(NUIOOU'(1 << (i % NUIOOU)), NBITS'(100 + i), 1'b0, 1'b0);
        check("ovf_set", 64'(ovf), 64'd1);
        check("ovf_drops", 64'(drop_cnt), 64'd2);
        step('0, '0, 1'b0, 1'b1);
        check("clr_ovf", 64'(ovf), 64'd0);
        check("clr_drop", 64'(drop_cnt), 64'd0);
        check("clr_keeps_fifo", 64'(bus.m_valid), 64'd1);

        // Full with simultaneous push and pop: accepted, no drop.
        step(4'b0010, 28'd99, 1'b1, 1'b0);
        check("fullpp_ovf", 64'(ovf), 64'd0);
        check("fullpp_drop", 64'(drop_cnt), 64'd0);
        // Drop in the same cycle as clear: set wins, count restarts at one.
        step(4'b0001, 28'd7, 1'b0, 1'b1);
        check("setwins_ovf", 64'(ovf), 64'd1);
        check("setwins_drop", 64'(drop_cnt), 64'd1);
        drain();

        // Illegal strobe: flagged, nothing queued.
        step(4'b0011, 28'd55, 1'b1, 1'b0);
        check("illegal_err", 64'(err), 64'd1);
        check("illegal_noq", 64'(bus.m_valid), 64'd0);

        // Asynchronous reset mid-cycle with entries queued.
        for (int i = 0; i < 3; i++) step(4'b0100, NBITS'(200 + i), 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 64'(bus.m_valid), 64'd0);
        check("arst_err", 64'(err), 64'd0);
        check("arst_ovf", 64'(ovf), 64'd0);
        check("arst_data", 64'(bus.m_data), 64'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step('0, '0, 1'b1, 1'b0);

        // Randomized traffic: low-drain phase provokes overflow, high-drain phase empties.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 5 || r == 9) en = NUIOOU'(1 << $urandom_range(0, NUIOOU - 1));
            else if (r <= 7) en = '0;
            else begin
                en = '0;
                while ($countones(en) < 2) en = NUIOOU'($urandom);
            end
            step(en, NBITS'($urandom),
                 (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0));
        end
        drain();
        step('0, '0, 1'b1, 1'b0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rede_out_collector.md
Name: rede_out_collector

Overview:
- Sits directly downstream of the float processor wrapper.
- Captures each signed integer result presented on io_out when one bit of the one-hot out_en strobe is set, tags it with the output-port index, and queues it in a FIFO.
- Drains the FIFO to a system-side valid/ready stream, so the processor never stalls on its output ports.
- Flags lost samples and illegal strobes.

Parameters:
- NBITS, 28, width of io_out data word (signed).
- NUIOOU, 4, number of processor output ports (width of out_en).
- CHW, 2, width of channel tag; must satisfy 2**CHW >= NUIOOU.
- FDEPTH, 8, FIFO depth in entries; power of two, at least 2.
- CNTW, 8, width of saturating drop counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- io_out  in  NBITS  signed result word from processor wrapper.
- out_en  in  NUIOOU  one-hot write strobe per output port, one-cycle pulses.
- m_data  out  NBITS  head-of-FIFO data word.
- m_chan  out  CHW  head-of-FIFO port index (binary).
- m_valid  out  1  head entry valid.
- m_ready  in  1  consumer accepts head this cycle.
- ovf  out  1  sticky: at least one sample dropped on full FIFO.
- err  out  1  sticky: out_en had more than one bit set.
- drop_cnt  out  CNTW  saturating count of dropped samples.
- clr_err  in  1  synchronous clear of ovf, err, drop_cnt.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - count, read pointer and write pointer to 0.
  - m_valid=0, m_data=0, m_chan=0.
  - ovf=0, err=0, drop_cnt=0.
- Reset mid-operation discards all queued entries.
- Push request: out_en has exactly one bit set. The channel tag is the binary index of that bit. The entry is {tag, io_out} sampled at that edge.
- out_en=0: no action.
- out_en with two or more bits set: no push, err set at that edge, drop_cnt unchanged.
- Pop: m_valid=1 and m_ready=1 at a rising edge.
- FIFO is first-word-fall-through. m_valid=(count!=0). m_data and m_chan show the head entry whenever m_valid=1 and hold their last value when empty.
- Latency:
  - A push at edge k into an empty FIFO makes m_valid=1 with that entry visible in cycle k+1.
  - No combinational path from out_en or io_out to any output.
- m_data and m_chan are stable while m_valid=1 and m_ready=0.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged, both pointers advance.
- Full (count=FDEPTH):
  - Push with no pop in the same cycle: entry dropped, ovf set, drop_cnt += 1, saturating at all-ones.
  - Push with pop in the same cycle: accepted, no drop.
- Empty: m_ready is ignored and there is no pop.
- Pointers wrap modulo FDEPTH.
- clr_err=1 at an edge clears ovf, err and drop_cnt.
  - If a drop or illegal strobe occurs in the same cycle, the set wins: flag=1, drop_cnt=1 for a drop.
  - clr_err does not affect FIFO contents.
- io_out is passed through bit-exact, with no sign manipulation.

Test Plan:
- Reset then idle:
  - Stimulus: rst low 3 cycles, release, out_en=0 for 10 cycles.
  - Required: m_valid=0, m_data=0, m_chan=0, ovf=0, err=0, drop_cnt=0 throughout.
- Single push, latency:
  - Stimulus: out_en=4'b0100 with io_out=-5 (28'hFFFFFFB) at edge k, m_ready=1.
  - Required: cycle k+1 shows m_valid=1, m_data=28'hFFFFFFB, m_chan=2. Cycle k+2 shows m_valid=0.
- Ordering under backpressure:
  - Stimulus: m_ready=0; push ports 0,3,1 with data 10,20,30 on consecutive cycles; then m_ready=1.
  - Required: output sequence (0,10), (3,20), (1,30), one per cycle, then m_valid=0.
- Overflow:
  - Stimulus: m_ready=0; 10 pushes with FDEPTH=8.
  - Required: count stays 8, ovf=1, drop_cnt=2. Draining yields the first 8 values in order.
  - Then pulse clr_err: ovf=0, drop_cnt=0.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full, m_ready=1, push value 99 on port 1 in the same cycle.
  - Required: no drop, ovf stays 0. Value 99 emerges 8th after the popped entry.
- Illegal strobe and reset mid-stream:
  - Stimulus: out_en=4'b0011.
  - Required: err=1, no entry queued.
  - Stimulus: with 3 entries queued, rst pulsed low asynchronously mid-cycle.
  - Required: m_valid=0 immediately, count=0, err=0.
